// File: rtl/shift_pkg.sv
// Shared definitions for the shift units: default datapath sizes, the
// right-shift FSM state encoding and the per-iteration shift mode.
package shift_pkg;

  localparam int SHIFT_DEF_WIDTH = 32;
  localparam int SHIFT_DEF_SHW   = 5;

  typedef enum logic [1:0] {
    SHR_IDLE  = 2'd0,
    SHR_SHIFT = 2'd1,
    SHR_DONE  = 2'd2
  } shr_state_e;

  typedef enum logic [1:0] {
    SHR_MODE_ROT = 2'd0,
    SHR_MODE_LOG = 2'd1,
    SHR_MODE_ARI = 2'd2
  } shr_mode_e;

endpackage

// File: rtl/shr_step.sv
// One iteration of the right-shift unit: shifts value right by k bit
// positions, as a rotate, a logical (zero-fill) or an arithmetic
// (sign-fill) shift depending on mode. Purely combinational.
module shr_step
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_DEF_WIDTH,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  shr_mode_e        mode,
  output logic [WIDTH-1:0] result
);

  int unsigned        k_int;
  int unsigned        k_rot;
  logic [2*WIDTH-1:0] dbl;

  // Select the shifted value for the requested mode; k may reach or exceed
  // WIDTH when STEP is large, so the shifts saturate and the rotate wraps.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    result = '0;
    k_int  = 32'(k);
    k_rot  = k_int % WIDTH;
    dbl    = {value, value} >> k_rot;
    case (mode)
      SHR_MODE_ROT: result = dbl[WIDTH-1:0];
      SHR_MODE_LOG: result = (k_int >= WIDTH) ? '0 : (value >> k_int);
      SHR_MODE_ARI: result = (k_int >= WIDTH) ? {WIDTH{value[WIDTH-1]}}
                                              : WIDTH'($signed(value) >>> k_int);
      default:      result = value;
    endcase
  end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right-shift unit. Accepts an operand and a shift amount over a
// valid/ready handshake, shifts STEP positions per clock and presents the
// rotate, logical and arithmetic right-shift results together.
// Optional feature: define SHIFT_RIGHT_SEQ_FLUSH_EN to add a flush input
// that aborts any operation and returns the FSM to IDLE.
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_DEF_WIDTH,
  parameter int SHW   = SHIFT_DEF_SHW,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_RIGHT_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sr1,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rot,
  output logic [WIDTH-1:0] log_shift,
  output logic [WIDTH-1:0] ari_shift,
  output logic             busy
);

  localparam int KW = $clog2(STEP + 1);

  shr_state_e       state, state_nxt;
  logic [SHW-1:0]   remaining;
  logic [KW-1:0]    k;
  logic             accept;
  logic             step_en;
  logic             flush_now;
  logic [WIDTH-1:0] rot_step, log_step, ari_step;

`ifdef SHIFT_RIGHT_SEQ_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Bit positions to shift this cycle: STEP, or whatever is left if less.
  always_comb begin
    if ({1'b0, remaining} < (SHW + 1)'(STEP)) k = KW'(remaining);
    else                                       k = KW'(STEP);
  end

  shr_step #(.WIDTH(WIDTH), .KW(KW)) u_step_rot (
    .value (rot),       .k(k), .mode(SHR_MODE_ROT), .result(rot_step)
  );
  shr_step #(.WIDTH(WIDTH), .KW(KW)) u_step_log (
    .value (log_shift), .k(k), .mode(SHR_MODE_LOG), .result(log_step)
  );
  shr_step #(.WIDTH(WIDTH), .KW(KW)) u_step_ari (
    .value (ari_shift), .k(k), .mode(SHR_MODE_ARI), .result(ari_step)
  );

  // Next-state, handshake outputs and datapath enables; flush overrides all.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      SHR_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (shamt == '0) ? SHR_DONE : SHR_SHIFT;
        end
      end
      SHR_SHIFT: begin
        step_en = 1'b1;
        if (remaining == SHW'(k)) state_nxt = SHR_DONE;
      end
      SHR_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = SHR_IDLE;
      end
      default: state_nxt = SHR_IDLE;
    endcase
    if (flush_now) begin
      state_nxt = SHR_IDLE;
      accept    = 1'b0;
      step_en   = 1'b0;
    end
  end

  assign busy = (state != SHR_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) state <= SHR_IDLE;
    else        state <= state_nxt;
  end

  // Result registers and remaining-count: load on accept, iterate in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the results are plain registers, not a memory, so they take the
    // async reset; a dropped transaction therefore leaves zeros visible.
    if (!rst_n) begin
      rot       <= '0;
      log_shift <= '0;
      ari_shift <= '0;
      remaining <= '0;
    end else begin
      if (accept) begin
        rot       <= sr1;
        log_shift <= sr1;
        ari_shift <= sr1;
        remaining <= shamt;
      end else if (step_en) begin
        rot       <= rot_step;
        log_shift <= log_step;
        ari_shift <= ari_step;
        remaining <= remaining - SHW'(k);
      end
      if (flush_now) remaining <= '0;
    end
  end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right-shift unit for the CPU datapath. It is the right-direction counterpart to the existing single-cycle left shift/rotate unit.
- Accepts one operand and a shift amount through a valid/ready handshake.
- Iterates STEP bit positions per clock and produces three results together: rotate-right, logical-shift-right and arithmetic-shift-right.
- Sits beside the ALU and serves SRL/SRA/ROR instructions. The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width.
- SHW, 5, shift-amount width; amounts range 0..2^SHW-1.
- STEP, 1, bit positions shifted per clock. Must be a power of two, at most 2^SHW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  unit can accept a request.
- sr1  in  WIDTH  operand to shift.
- shamt  in  SHW  shift amount.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- rot  out  WIDTH  sr1 rotated right by shamt.
- log_shift  out  WIDTH  sr1 logically shifted right (zero fill).
- ari_shift  out  WIDTH  sr1 arithmetically shifted right (sign fill from sr1[WIDTH-1]).
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - rot, log_shift and ari_shift all 0;
  - remaining counter 0.
- Reset mid-operation drops the transaction silently. No result is produced.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, latch sr1 into all three result registers and shamt into remaining. Next state is DONE if shamt==0, else SHIFT.
  - SHIFT: in_ready=0. Each cycle, k = min(STEP, remaining).
    - rot <= rotate right by k.
    - log_shift <= logical right by k.
    - ari_shift <= arithmetic right by k.
    - remaining <= remaining-k.
    - When remaining-k==0, go to DONE.
  - DONE: out_valid=1 and results are held stable. When out_ready is high, go to IDLE and out_valid falls next cycle.
- Latency from the accept edge to out_valid high: 1 + ceil(shamt/STEP) cycles. shamt=0 gives 1 cycle.
- No new request is accepted in SHIFT or DONE; in_valid is ignored there. The upstream stage must hold its request until in_ready.
- Results are register outputs and stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- Amount rules:
  - shamt equal to 2^SHW-1 is legal.
  - A full-width rotate (shamt mod WIDTH == 0, shamt≠0) returns the original operand. This only arises when WIDTH < 2^SHW.
  - Logical/arithmetic shifts by ≥WIDTH saturate to 0 / all-sign-bits.
- in_valid asserted on the same cycle DONE completes is not accepted. Acceptance occurs on the following IDLE cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: SHIFT_RIGHT_SEQ_FLUSH_EN.
- Defined: adds input port flush (1 bit). flush high in any state forces state=IDLE and out_valid=0 on the next edge, and zeroes remaining. Result registers keep their last value. Flush has priority over acceptance in IDLE.
- Undefined: no flush port; the FSM is as above.

Decomposition:
- Package shift_pkg holds:
  - state encoding constants SHR_IDLE=2'd0, SHR_SHIFT=2'd1, SHR_DONE=2'd2;
  - default WIDTH/SHW constants shared with the left shift unit.
- One combinational sub-module, shr_step. It takes value, k and mode, returns the one-iteration shift, and is instantiated three times (rotate, logical, arithmetic).
- The FSM and counter stay in the top module.

Test Plan:
1. sr1=32'h8000_0001, shamt=0, STEP=1 → out_valid one cycle after accept; rot=log_shift=ari_shift=32'h8000_0001.
2. sr1=32'h8000_00F0, shamt=4, STEP=1 → out_valid 5 cycles after accept; rot=32'h0800_000F, log_shift=32'h0800_000F, ari_shift=32'hF800_000F.
3. sr1=32'hF000_0000, shamt=31, STEP=4 → 1+8 cycles; rot=32'hE000_0001, log_shift=32'h0000_0001, ari_shift=32'hFFFF_FFFF.
4. Backpressure: case 2 with out_ready=0 for 10 cycles → outputs stable, in_ready=0, new in_valid ignored; out_ready=1 → IDLE next cycle, then a queued request is accepted.
5. Async reset asserted during SHIFT (shamt=20) → all outputs 0 and in_ready=1 immediately, with no out_valid pulse afterwards.
6. With SHIFT_RIGHT_SEQ_FLUSH_EN defined, flush during SHIFT → IDLE next cycle, out_valid stays 0; next request sr1=32'h0000_0100, shamt=8 → rot=log_shift=ari_shift=32'h0000_0001.
